// File: rtl/derotator_if.sv
// derotator_if: START/BUSY/VALID handshake bundle
// between the geometry pipeline and the derotator.
interface derotator_if;
  logic       ENB;
  logic       START;
  logic [7:0] Xcoord;
  logic [7:0] Ycoord;
  logic [7:0] Angle;
  logic [7:0] Mag;
  logic       RANGE_ERR;
  logic       BUSY;
  logic       VALID;

  modport master (
    output ENB, START, Xcoord, Ycoord,
    input  Angle, Mag, RANGE_ERR, BUSY, VALID
  );

  modport slave (
    input  ENB, START, Xcoord, Ycoord,
    output Angle, Mag, RANGE_ERR, BUSY, VALID
  );
endinterface

// File: rtl/derotator.sv
// derotator: recovers Q1.7 angle/magnitude of (X,Y), one bit per edge.
// Define DEROTATOR_SAT_EN to clamp xt instead of wrapping it.
module derotator (
  input  logic        ACLK,
  input  logic        ARESETN,
  derotator_if.slave  bus
);

  typedef enum logic {IDLE, ITER} state_t;

  state_t state_q, state_d;

  logic signed [7:0] x_q, x_d;
  logic signed [7:0] y_q, y_d;
  logic [7:0] acc_q, acc_d;
  logic [2:0] idx_q, idx_d;
  logic       err_q, err_d;
  logic [7:0] angle_q, angle_d;
  logic [7:0] mag_q, mag_d;
  logic       rerr_q, rerr_d;
  logic       valid_q, valid_d;

  logic [7:0] sin_c, cos_c;
  logic [7:0] mcy, msx, mcx, msy;
  logic [8:0] yt;
  logic [7:0] xt;
  logic       accept;
  logic [7:0] x_nxt, acc_nxt;
`ifdef DEROTATOR_SAT_EN
  logic [8:0] xs;
`endif

  function automatic logic [7:0] mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0]  m;
    logic [16:0] p;
    logic [8:0]  q;
    m = a[7] ? (9'd0 - {1'b1, a}) : {1'b0, a};
    p = {8'd0, m} * {9'd0, b};
    q = 9'(p >> 7);
    return a[7] ? 8'(9'd0 - q) : 8'(q);
  endfunction

  function automatic logic [7:0] sin_of(input logic [2:0] k);
    logic [7:0] r;
    unique case (k)
      3'd7: r = 8'h6C;
      3'd6: r = 8'h3D;
      3'd5: r = 8'h1F;
      3'd4: r = 8'h0F;
      3'd3: r = 8'h08;
      3'd2: r = 8'h03;
      3'd1: r = 8'h01;
      default: r = 8'h01;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] cos_of(input logic [2:0] k);
    logic [7:0] r;
    unique case (k)
      3'd7: r = 8'h45;
      3'd6: r = 8'h70;
      3'd5: r = 8'h7C;
      3'd4: r = 8'h7E;
      3'd3: r = 8'h7F;
      3'd2: r = 8'h7F;
      3'd1: r = 8'h7F;
      default: r = 8'h80;
    endcase
    return r;
  endfunction

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
    end else if (bus.ENB) begin
      state_q <= state_d;
    end
  end

  // Next-state: one START opens 8 iteration edges
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.START) state_d = ITER;
      ITER: if (idx_q == 3'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Trial clockwise rotation for the current bit
  always_comb begin
    sin_c = sin_of(idx_q);
    cos_c = cos_of(idx_q);
    mcy = mul(y_q, cos_c);
    msx = mul(x_q, sin_c);
    mcx = mul(x_q, cos_c);
    msy = mul(y_q, sin_c);
    yt = {mcy[7], mcy} - {msx[7], msx};
`ifdef DEROTATOR_SAT_EN
    xs = {mcx[7], mcx} + {msy[7], msy};
    unique case (xs[8:7])
      2'b01:   xt = 8'h7F;
      2'b10:   xt = 8'h80;
      default: xt = xs[7:0];
    endcase
`else
    xt = mcx + msy;
`endif
    accept = !err_q && !yt[8] && (yt != 9'd0);
    x_nxt = accept ? xt : x_q;
    acc_nxt = accept ? (acc_q | (8'd1 << idx_q)) : acc_q;
  end

  // Datapath and result register updates
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    acc_d = acc_q;
    idx_d = idx_q;
    err_d = err_q;
    angle_d = angle_q;
    mag_d = mag_q;
    rerr_d = rerr_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          x_d = bus.Xcoord;
          y_d = bus.Ycoord;
          acc_d = 8'd0;
          idx_d = 3'd7;
          err_d = bus.Ycoord[7];
        end
      end
      ITER: begin
        x_d = x_nxt;
        acc_d = acc_nxt;
        if (accept) y_d = yt[7:0];
        if (idx_q == 3'd0) begin
          angle_d = err_q ? 8'd0 : acc_nxt;
          mag_d = x_nxt;
          rerr_d = err_q;
          valid_d = 1'b1;
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end
      default: ;
    endcase
  end

  // Working and result flops, frozen while ENB is low
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      x_q <= '0;
      y_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
      angle_q <= '0;
      mag_q <= '0;
      rerr_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (bus.ENB) begin
      x_q <= x_d;
      y_q <= y_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      err_q <= err_d;
      angle_q <= angle_d;
      mag_q <= mag_d;
      rerr_q <= rerr_d;
      valid_q <= valid_d;
    end
  end

  // Outputs
  always_comb begin
    bus.BUSY = (state_q == ITER);
    bus.VALID = valid_q;
    bus.Angle = angle_q;
    bus.Mag = mag_q;
    bus.RANGE_ERR = rerr_q;
  end

endmodule

// File: tb/tb_derotator.sv
// tb_derotator: directed + random checks of derotator
// against an integer model of the derotation rules.
module tb_derotator;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int total = 0;
  int passed = 0;

  localparam int SIN_T [8] = '{1, 1, 3, 8, 15, 31, 61, 108};
  localparam int COS_T [8] = '{128, 127, 127, 127, 126, 124, 112, 69};

  derotator_if bus();

  derotator u_dut (
    .ACLK(aclk),
    .ARESETN(aresetn),
    .bus(bus.slave)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic int s8(input int v);
    int r;
    r = v & 255;
    return (r >= 128) ? r - 256 : r;
  endfunction

  function automatic int mulm(input int a, input int b);
    int m;
    m = (a < 0) ? -a : a;
    m = (m * b) / 128;
    return (a < 0) ? -m : m;
  endfunction

  task automatic model(input int xin, input int yin,
                       output int ang, output int mag, output int err);
    int x, y, yt, xt, acc;
    x = s8(xin);
    y = s8(yin);
    err = (y < 0) ? 1 : 0;
    acc = 0;
    for (int k = 7; k >= 0; k--) begin
      yt = mulm(y, COS_T[k]) - mulm(x, SIN_T[k]);
      xt = mulm(x, COS_T[k]) + mulm(y, SIN_T[k]);
      if (err == 0 && yt > 0) begin
`ifdef DEROTATOR_SAT_EN
        if (xt > 127) xt = 127;
        if (xt < -128) xt = -128;
`else
        xt = s8(xt);
`endif
        x = xt;
        y = s8(yt);
        acc += (1 << k);
      end
    end
    ang = (err != 0) ? 0 : acc;
    mag = x & 255;
  endtask

  task automatic start_op(input logic [7:0] x, input logic [7:0] y);
    bus.Xcoord = x;
    bus.Ycoord = y;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.VALID !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_res(input string tag, input logic [7:0] x,
                           input logic [7:0] y);
    int a, m, e;
    model(int'(x), int'(y), a, m, e);
    chk({tag, "_valid"}, 32'(bus.VALID), 1);
    chk({tag, "_busy"}, 32'(bus.BUSY), 0);
    chk({tag, "_angle"}, 32'(bus.Angle), a);
    chk({tag, "_mag"}, 32'(bus.Mag), m);
    chk({tag, "_rerr"}, 32'(bus.RANGE_ERR), e);
  endtask

  task automatic no_valid(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.VALID === 1'b1) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    int c;
    int n;
    logic [7:0] rx, ry;

    bus.ENB = 1'b1;
    bus.START = 1'b1;
    bus.Xcoord = 8'h55;
    bus.Ycoord = 8'h11;
    repeat (3) tick();
    chk("rst_angle", 32'(bus.Angle), 0);
    chk("rst_mag", 32'(bus.Mag), 0);
    chk("rst_busy", 32'(bus.BUSY), 0);
    chk("rst_valid", 32'(bus.VALID), 0);
    chk("rst_rerr", 32'(bus.RANGE_ERR), 0);
    bus.START = 1'b0;
    aresetn = 1'b1;
    no_valid("post_rst_quiet", 12);

    start_op(8'h40, 8'h00);
    chk("x_busy", 32'(bus.BUSY), 1);
    wait_valid(c);
    chk("x_lat", c, 8);
    chk("x_angle", 32'(bus.Angle), 8'h00);
    chk("x_mag", 32'(bus.Mag), 8'h40);
    chk("x_rerr", 32'(bus.RANGE_ERR), 0);
    tick();
    chk("x_valid_drop", 32'(bus.VALID), 0);
    chk("x_angle_hold", 32'(bus.Mag), 8'h40);

    start_op(8'h00, 8'h40);
    wait_valid(c);
    chk("pi2_lat", c, 8);
    chk("pi2_angle", 32'(bus.Angle), 8'hC7);
    chk("pi2_mag", 32'(bus.Mag), 8'h3D);
    chk("pi2_rerr", 32'(bus.RANGE_ERR), 0);
    tick();

    start_op(8'h20, 8'hC0);
    wait_valid(c);
    chk("neg_lat", c, 8);
    chk("neg_angle", 32'(bus.Angle), 8'h00);
    chk("neg_rerr", 32'(bus.RANGE_ERR), 1);
    chk("neg_mag", 32'(bus.Mag), 8'h20);
    tick();

    start_op(8'h30, 8'h25);
    for (int i = 0; i < 7; i++) begin
      bus.START = 1'b1;
      bus.Xcoord = 8'(i * 17);
      bus.Ycoord = 8'(i * 9 + 3);
      tick();
    end
    bus.START = 1'b0;
    wait_valid(c);
    chk("ign_lat", 7 + c, 8);
    check_res("ign", 8'h30, 8'h25);
    tick();
    chk("ign_no_requeue", 32'(bus.BUSY), 0);

    start_op(8'h50, 8'h30);
    repeat (3) tick();
    bus.ENB = 1'b0;
    repeat (5) tick();
    chk("enb_hold_busy", 32'(bus.BUSY), 1);
    chk("enb_hold_valid", 32'(bus.VALID), 0);
    bus.ENB = 1'b1;
    wait_valid(c);
    chk("enb_lat", 8 + c, 13);
    check_res("enb", 8'h50, 8'h30);

    bus.ENB = 1'b0;
    repeat (2) tick();
    chk("stretch_valid", 32'(bus.VALID), 1);
    bus.ENB = 1'b1;
    bus.START = 1'b1;
    bus.Xcoord = 8'h33;
    bus.Ycoord = 8'h44;
    tick();
    bus.START = 1'b0;
    chk("b2b_valid_drop", 32'(bus.VALID), 0);
    chk("b2b_busy", 32'(bus.BUSY), 1);
    wait_valid(c);
    chk("b2b_lat", c, 8);
    check_res("b2b", 8'h33, 8'h44);
    tick();

    start_op(8'h7F, 8'h7F);
    wait_valid(c);
    chk("big_lat", c, 8);
    check_res("big", 8'h7F, 8'h7F);
`ifdef DEROTATOR_SAT_EN
    chk("big_sat_mag", 32'(bus.Mag), 8'h7F);
`endif
    tick();

    start_op(8'h7F, 8'h7F);
    repeat (4) tick();
    #2 aresetn = 1'b0;
    #2;
    chk("mid_rst_angle", 32'(bus.Angle), 0);
    chk("mid_rst_mag", 32'(bus.Mag), 0);
    chk("mid_rst_busy", 32'(bus.BUSY), 0);
    chk("mid_rst_valid", 32'(bus.VALID), 0);
    chk("mid_rst_rerr", 32'(bus.RANGE_ERR), 0);
    aresetn = 1'b1;
    no_valid("mid_rst_quiet", 12);

    n = 0;
    for (int i = 0; i < 24; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      start_op(rx, ry);
      wait_valid(c);
      chk("rnd_lat", c, 8);
      check_res("rnd", rx, ry);
      tick();
      n++;
    end
    chk("rnd_count", n, 24);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/derotator.md
# derotator

- Inverse of the fixed-point point rotator.
- Takes a signed Q1.7 point (X, Y) and iteratively recovers the 8-bit binary-weighted rotation angle and the vector magnitude.
- Uses the same per-bit sin/cos constant table and the same Angle encoding, so its Angle output can be fed straight back into the rotator.
- Multicycle: one angle bit resolved per enabled ACLK edge, with a START/BUSY/VALID handshake toward the geometry pipeline.

## Interface
- No parameters; widths fixed at 8 bits.
- ACLK  in  1  clock, rising-edge.
- ARESETN  in  1  asynchronous active-low reset.
- ENB  in  1  clock enable; when low, all state and outputs hold.
- START  in  1  request; sampled only in IDLE with ENB high.
- Xcoord  in  8  signed Q1.7 X (value = code/128).
- Ycoord  in  8  signed Q1.7 Y.
- Angle  out  8  unsigned; bit k weighs 2^(k-7) rad (0x80 ≈ 1 rad); held until next result.
- Mag  out  8  signed Q1.7 final X (≈ vector length); held.
- RANGE_ERR  out  1  set with VALID when Ycoord was negative; held.
- BUSY  out  1  high while not IDLE.
- VALID  out  1  one-cycle pulse when Angle/Mag/RANGE_ERR update.

## Operation
- States: IDLE, ITER.
- Constant table (sin, cos) per bit, unsigned:
  - bit7 0x6C,0x45
  - bit6 0x3D,0x70
  - bit5 0x1F,0x7C
  - bit4 0x0F,0x7E
  - bit3 0x08,0x7F
  - bit2 0x03,0x7F
  - bit1 0x01,0x7F
  - bit0 0x01,0x80
- mul(a,b): a signed 8-bit, b unsigned 8-bit; result = sign(a)·floor(|a|·b/128), 8-bit. |−128| is treated as 128.
- IDLE, START=1, ENB=1: load x←Xcoord, y←Ycoord, acc←0, idx←7, err←Ycoord[7]; go to ITER.
- ITER step at idx (trial clockwise rotation):
  - yt = mul(y,cos) − mul(x,sin), computed 9-bit signed.
  - xt = mul(x,cos) + mul(y,sin).
  - If err=0 and yt>0 (strict): accept, x←xt, y←yt[7:0], acc[idx]←1.
  - Otherwise x, y and acc are unchanged.
- At idx=0, the same edge registers Angle←(err ? 0x00 : final acc), Mag←final x, RANGE_ERR←err, VALID←1, and returns to IDLE.
- START in ITER is ignored, not queued.
- xt overflow: wraps modulo 256 unless saturation is compiled in (see Configuration).

## Timing
- Reset (async assert, synchronous-release flops): state IDLE; Angle, Mag = 0x00; RANGE_ERR, BUSY, VALID = 0.
- Reset mid-ITER aborts; no VALID is produced.
- Latency: START sampled at edge N ⇒ VALID high during the cycle after edge N+8 (9 enabled edges total).
- BUSY is high after edge N through edge N+8; it is low in the VALID cycle.
- Back-to-back: START may be high in the VALID cycle and is accepted at that edge. Throughput is 1 result per 9 enabled edges.
- ENB low: the FSM, idx and registers freeze. A VALID pulse in progress stretches until the next enabled edge.
- VALID deasserts on the first enabled edge after it rises.

## Configuration
- DEROTATOR_SAT_EN defined: xt is computed 9-bit and clamped to [0x80, 0x7F] before being stored. Mag never wraps.
- Undefined: xt is truncated to 8 bits (wrap).
  - Inputs with |(X,Y)| ≥ 1.0 give undefined Mag.
  - Angle is still computed from the wrapped state.

## Test plan
- Reset: ARESETN low with ENB=1 and START=1 -> Angle=0x00, Mag=0x00, BUSY=0, VALID=0; after release, no VALID until a START.
- X=0x40, Y=0x00, START -> every trial rejected; 9 edges later VALID with Angle=0x00, Mag=0x40, RANGE_ERR=0.
- X=0x00, Y=0x40 (π/2), START -> accepts bits 7,6,2,1,0; VALID with Angle=0xC7, Mag=0x3D.
- Y=0xC0 (negative), X=0x20 -> VALID after 9 edges with RANGE_ERR=1, Angle=0x00.
- Protocol:
  - START re-asserted on edges N+1..N+7 is ignored.
  - ENB held low for 5 cycles mid-ITER -> VALID delayed by exactly 5 cycles with an unchanged result.
  - START in the VALID cycle -> second VALID 9 edges later.
- X=0x7F, Y=0x7F:
  - with DEROTATOR_SAT_EN -> Mag=0x7F;
  - without -> Mag matches the wrapped-model reference.
  - In both builds, ARESETN pulsed at idx=3 -> no VALID, outputs 0.
